// File: rtl/connect_four_input_ctrl.sv
// connect_four_input_ctrl
// Button front end for the connect_four game core. Three raw, bouncy
// buttons are synchronised and debounced, and then turned into
// single-cycle move/drop strobes. Left and right auto-repeat while held.
//
// Output protocol: move_left, move_right and drop_piece are fire-and-forget
// strobes. Each one is high for exactly one clk_25MHz cycle per event, and
// there is no ready/acknowledge path. The game core must act on a strobe in
// the cycle it is high. At most one of the three strobes is high in any
// cycle.
module connect_four_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_RATE     = 3750000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       btn_left_raw,
    input  logic       btn_right_raw,
    input  logic       btn_drop_raw,
    input  logic       game_over,
    output logic       move_left,
    output logic       move_right,
    output logic       drop_piece,
    output logic [2:0] btn_state
);

    // Bit positions of the three buttons in every 3-bit vector below.
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_D = 2;

    // Counter terminal values. The counters clear on reaching these
    // values, so they never wrap.
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_e;

    // Raw inputs, packed as {drop, right, left}.
    logic [2:0] raw;
    assign raw = {btn_drop_raw, btn_right_raw, btn_left_raw};

    // Two-flop synchronisers.
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;

    // Debounced levels, their one-cycle-delayed copies, and the per-button
    // counters.
    logic [2:0]            stable_q, stable_d;
    logic [2:0]            prev_q, prev_d;
    logic [2:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

    // Repeat FSM state.
    rep_state_e       state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;

    // Registered strobes.
    logic move_left_q, move_left_d;
    logic move_right_q, move_right_d;
    logic drop_piece_q, drop_piece_d;

    // Combinational event signals.
    logic [2:0] press;
    logic       emit_l;
    logic       emit_r;
    logic       dir_held;
    logic       other_held;

    // Synchroniser next-state: shift each raw level through two flops.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    // Debounce. The counter runs only while the synchronised level differs
    // from the stable level. A new level is accepted on the
    // DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        prev_d = stable_q;
    end

    // A press event is high for the one cycle after a stable level rises.
    assign press = stable_q & ~prev_q;

    // Selects the held level of the current repeat direction and of the
    // opposite direction.
    assign dir_held   = (dir_q == DIR_L) ? stable_q[BTN_L] : stable_q[BTN_R];
    assign other_held = (dir_q == DIR_L) ? stable_q[BTN_R] : stable_q[BTN_L];

    // Repeat FSM next-state logic and move-strobe requests.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        rep_cnt_d = rep_cnt_q;
        emit_l    = 1'b0;
        emit_r    = 1'b0;

        if (game_over) begin
            // End of game: the FSM is parked. Any press arriving now is lost.
            state_d   = ST_IDLE;
            rep_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rep_cnt_d = '0;
                    // A press counts only when the other direction is not
                    // also down. This also rejects simultaneous presses.
                    if (press[BTN_L] && !stable_q[BTN_R]) begin
                        emit_l  = 1'b1;
                        dir_d   = DIR_L;
                        state_d = ST_DELAY;
                    end else if (press[BTN_R] && !stable_q[BTN_L]) begin
                        emit_r  = 1'b1;
                        dir_d   = DIR_R;
                        state_d = ST_DELAY;
                    end
                end

                ST_DELAY, ST_REPEAT: begin
                    if (!dir_held || other_held) begin
                        // Release, or a conflicting direction: stop silently.
                        state_d   = ST_IDLE;
                        rep_cnt_d = '0;
                    end else if ((state_q == ST_DELAY && rep_cnt_q == DELAY_LAST) ||
                                 (state_q == ST_REPEAT && rep_cnt_q == RATE_LAST)) begin
                        emit_l    = (dir_q == DIR_L);
                        emit_r    = (dir_q == DIR_R);
                        rep_cnt_d = '0;
                        state_d   = ST_REPEAT;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    rep_cnt_d = '0;
                end
            endcase
        end
    end

    // Strobe arbitration. Drop has priority over a move in the same cycle.
    // The suppressed move does not disturb the FSM's repeat timing.
    always_comb begin
        drop_piece_d = press[BTN_D] && !game_over;
        move_left_d  = emit_l && !drop_piece_d;
        move_right_d = emit_r && !drop_piece_d;
    end

    // State register for all of the above, with synchronous active-low reset.
    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            prev_q       <= '0;
            db_cnt_q     <= '0;
            state_q      <= ST_IDLE;
            dir_q        <= DIR_L;
            rep_cnt_q    <= '0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            drop_piece_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            prev_q       <= prev_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            dir_q        <= dir_d;
            rep_cnt_q    <= rep_cnt_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
            drop_piece_q <= drop_piece_d;
        end
    end

    assign move_left  = move_left_q;
    assign move_right = move_right_q;
    assign drop_piece = drop_piece_q;
    assign btn_state  = stable_q;

endmodule

// File: tb/tb_connect_four_input_ctrl.sv
// Testbench for connect_four_input_ctrl with small timing parameters.
// Expected strobes are queued as {edge_index, code} when stimulus is
// driven. A negedge monitor pops and compares each strobe the DUT produces.
module tb_connect_four_input_ctrl;

  localparam int W = 34;
  localparam logic [1:0] C_L = 2'd1;
  localparam logic [1:0] C_R = 2'd2;
  localparam logic [1:0] C_D = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       btn_left_raw, btn_right_raw, btn_drop_raw, game_over;
  logic       move_left, move_right, drop_piece;
  logic [2:0] btn_state;

  // cyc equals the index of the most recent rising edge.
  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  connect_four_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(8),
    .CNT_W(24)
  ) dut (
    .clk_25MHz(clk),
    .rst_n(rst_n),
    .btn_left_raw(btn_left_raw),
    .btn_right_raw(btn_right_raw),
    .btn_drop_raw(btn_drop_raw),
    .game_over(game_over),
    .move_left(move_left),
    .move_right(move_right),
    .drop_piece(drop_piece),
    .btn_state(btn_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [31:0] at, input logic [1:0] code);
    exp_q.push_back({at, code});
  endtask

  logic [1:0]   mon_code;
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;
  always @(negedge clk) begin
    if (move_left || move_right || drop_piece) begin
      mon_code = drop_piece ? C_D : (move_right ? C_R : C_L);
      mon_got  = {cyc, mon_code};
      check("onehot", 64'($countones({move_left, move_right, drop_piece})), 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(mon_got), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("strobe", 64'(mon_got), 64'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input logic [31:0] target);
    while (cyc < target) tick(1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] t, tf, tr, tp;

  initial begin
    rst_n = 1'b0;
    btn_left_raw = 1'b0;
    btn_right_raw = 1'b0;
    btn_drop_raw = 1'b0;
    game_over = 1'b0;
    tick(3);
    check("reset_outs", 64'({move_left, move_right, drop_piece, btn_state}), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Clean left press held into repeat, then released.
    t = cyc;
    btn_left_raw = 1'b1;
    push_exp(t + 7, C_L);
    push_exp(t + 27, C_L);
    push_exp(t + 35, C_L);
    push_exp(t + 43, C_L);
    wait_cyc(t + 5);
    check("s1_lat_pre", 64'(btn_state), 64'd0);
    wait_cyc(t + 6);
    check("s1_lat", 64'(btn_state), 64'b001);
    wait_cyc(t + 44);
    btn_left_raw = 1'b0;
    wait_cyc(t + 110);
    check("s1_drain", 64'(exp_q.size()), 64'd0);
    check("s1_released", 64'(btn_state), 64'd0);

    // Bouncing drop button, then a steady hold with no repeat.
    for (int k = 0; k < 5; k++) begin
      btn_drop_raw = 1'b1;
      tick(3);
      btn_drop_raw = 1'b0;
      tick(2);
    end
    btn_drop_raw = 1'b1;
    tf = cyc;
    push_exp(tf + 7, C_D);
    wait_cyc(tf + 5);
    check("s2_bounce_lvl", 64'(btn_state), 64'd0);
    wait_cyc(tf + 6);
    check("s2_lat", 64'(btn_state), 64'b100);
    wait_cyc(tf + 110);
    check("s2_drain", 64'(exp_q.size()), 64'd0);
    btn_drop_raw = 1'b0;
    tick(20);

    // Left and right pressed on the same edge.
    t = cyc;
    btn_left_raw = 1'b1;
    btn_right_raw = 1'b1;
    wait_cyc(t + 6);
    check("s3_both_lvl", 64'(btn_state), 64'b011);
    wait_cyc(t + 106);
    check("s3_quiet", 64'(exp_q.size()), 64'd0);
    tr = cyc;
    btn_right_raw = 1'b0;
    wait_cyc(tr + 6);
    check("s3_right_rel", 64'(btn_state), 64'b001);
    wait_cyc(tr + 46);
    check("s3_drain", 64'(exp_q.size()), 64'd0);
    btn_left_raw = 1'b0;
    tick(20);

    // Drop lands on a repeat slot; the repeat grid must hold afterwards.
    t = cyc;
    btn_left_raw = 1'b1;
    push_exp(t + 7, C_L);
    push_exp(t + 27, C_L);
    push_exp(t + 35, C_L);
    push_exp(t + 43, C_D);
    push_exp(t + 51, C_L);
    push_exp(t + 59, C_L);
    wait_cyc(t + 36);
    btn_drop_raw = 1'b1;
    wait_cyc(t + 50);
    btn_drop_raw = 1'b0;
    wait_cyc(t + 60);
    btn_left_raw = 1'b0;
    wait_cyc(t + 100);
    check("s4_drain", 64'(exp_q.size()), 64'd0);

    // A press during game_over is lost; a re-press after it ends fires.
    game_over = 1'b1;
    t = cyc;
    btn_right_raw = 1'b1;
    wait_cyc(t + 6);
    check("s5_go_lvl", 64'(btn_state), 64'b010);
    wait_cyc(t + 20);
    game_over = 1'b0;
    wait_cyc(t + 60);
    check("s5_lost", 64'(exp_q.size()), 64'd0);
    btn_right_raw = 1'b0;
    tick(10);
    tp = cyc;
    btn_right_raw = 1'b1;
    push_exp(tp + 7, C_R);
    wait_cyc(tp + 10);
    btn_right_raw = 1'b0;
    wait_cyc(tp + 40);
    check("s5_drain", 64'(exp_q.size()), 64'd0);

    // One-cycle reset while left is repeating.
    t = cyc;
    btn_left_raw = 1'b1;
    push_exp(t + 7, C_L);
    push_exp(t + 27, C_L);
    push_exp(t + 35, C_L);
    wait_cyc(t + 38);
    rst_n = 1'b0;
    wait_cyc(t + 39);
    check("s6_rst_outs", 64'({move_left, move_right, drop_piece, btn_state}), 64'd0);
    check("s6_rst_pending", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b1;
    push_exp(t + 46, C_L);
    push_exp(t + 66, C_L);
    wait_cyc(t + 44);
    check("s6_lat_pre", 64'(btn_state), 64'd0);
    wait_cyc(t + 45);
    check("s6_lat", 64'(btn_state), 64'b001);
    wait_cyc(t + 67);
    btn_left_raw = 1'b0;
    wait_cyc(t + 110);
    check("s6_drain", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    tick(5);
    check("final_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
